datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Single-bus 16-bit processor datapath: eight general registers R0–R7, accumulator A, ALU and result register G, all sharing one internal data bus.
- External data enters the bus through a gated input.
- A separate control unit drives every enable; this block contains no sequencing logic.
- The bus value is exported for observation and for downstream logic.

Parameters:
- WIDTH, 16, data width of bus, R0–R7, A, G and ext_data.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- ext_data  input  WIDTH  external data word
- ext_data_en  input  1  drive ext_data onto bus
- reg_in_en  input  8  bit i loads bus into Ri
- reg_out_en  input  8  bit i drives Ri onto bus
- alu_reg_en  input  1  load bus into A
- alu_sel  input  1  0 = add, 1 = subtract
- g_reg_en  input  1  load ALU result into G
- alu_out_en  input  1  drive G onto bus
- bus  output  WIDTH  current bus value (combinational)
- bus_conflict  output  1  more than one bus source enabled (see Optional Feature)

Behaviour:
- Reset: rst_n low asynchronously clears R0–R7, A and G to 0.
  - While rst_n is low, clk edges have no effect.
  - Deassertion is sampled normally; the first load occurs on the first rising edge with rst_n high.
- Bus sources are ext_data (ext_data_en), Ri (reg_out_en[i]) and G (alu_out_en).
  - The bus is built with a mux/AND-OR structure; no internal tristates.
  - bus = bitwise OR of all enabled sources.
  - No source enabled gives bus = 0.
- bus is combinational from current enables and register contents; zero-cycle latency.
- Register loads on rising clk:
  - Ri <= bus for each i with reg_in_en[i] = 1; several registers may load the same value in one cycle.
  - A <= bus when alu_reg_en = 1.
  - G <= (alu_sel ? A − bus : A + bus) when g_reg_en = 1.
    - Arithmetic is modulo 2^WIDTH: carry/borrow discarded, wrap-around silent.
  - Registers without enable hold their value.
- Read and write of the same register in one cycle (reg_out_en[i] and reg_in_en[i]): Ri reloads its own old value, i.e. no change.
- G driving the bus while g_reg_en = 1: G captures A ± old G; no combinational loop, since G is registered.
- A and G loads in the same cycle: G uses the pre-edge value of A.
- Unknown or X controls are outside the contract; the bench must drive all enables to 0/1.

Optional Feature:
- Macro BUS_CONFLICT_CHECK_EN.
- Defined:
  - bus_conflict = 1 combinationally whenever two or more of {ext_data_en, reg_out_en[7:0], alu_out_en} are 1.
  - bus still carries the OR of the enabled sources.
  - In simulation a $error is printed at each rising clk where bus_conflict = 1.
- Undefined: bus_conflict is tied to 0 and no check logic is generated. Bus behaviour is unchanged.

Test Plan:
1. Reset: rst_n = 0 mid-cycle with R0 = 0x1234 → R0–R7, A, G read back 0 via reg_out_en; bus = 0 with no enables.
2. External load: ext_data = 0x0001, ext_data_en = 1, reg_in_en = 0x01 for one edge; then all off, reg_out_en = 0x01 → bus = 0x0001. ext_data changed to 0x0003 does not alter R0.
3. Empty-bus load: reg_in_en = 0x01 with no source enabled → R0 becomes 0x0000 after the edge.
4. Add: R1 = 5, R2 = 7. Cycle 1: reg_out_en = 0x02, alu_reg_en = 1. Cycle 2: reg_out_en = 0x04, alu_sel = 0, g_reg_en = 1. Cycle 3: alu_out_en = 1, reg_in_en = 0x08 → R3 = 12.
5. Subtract with wrap: A = 3, bus = 5, alu_sel = 1, g_reg_en = 1 → G = 0xFFFE. Then A = 0xFFFF plus bus 1 → G = 0x0000.
6. Conflict (macro defined): ext_data = 0x00F0 with ext_data_en = 1, and R0 = 0x000F with reg_out_en = 0x01 → bus = 0x00FF, bus_conflict = 1. Single source → bus_conflict = 0.

Source files
------------

// File: rtl/datapath.sv
// datapath: single-bus 16-bit processor datapath (R0-R7, accumulator A, ALU, result register G)
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   ext_data        - external word, placed on the bus when ext_data_en = 1
//   reg_in_en[i]    - Ri <= bus;  reg_out_en[i] - Ri drives the bus
//   alu_reg_en      - A <= bus
//   alu_sel         - 0: G <= A + bus, 1: G <= A - bus (modulo 2^WIDTH)
//   g_reg_en        - load ALU result into G;  alu_out_en - G drives the bus
//   bus             - combinational OR of all enabled sources (0 when none)
//   bus_conflict    - two or more sources enabled
//
// Optional feature: define BUS_CONFLICT_CHECK_EN to generate bus_conflict
// and a simulation $error on each clock edge with a conflict; otherwise
// bus_conflict is tied to 0.
module datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ext_data,
  input  logic             ext_data_en,
  input  logic [7:0]       reg_in_en,
  input  logic [7:0]       reg_out_en,
  input  logic             alu_reg_en,
  input  logic             alu_sel,
  input  logic             g_reg_en,
  input  logic             alu_out_en,
  output logic [WIDTH-1:0] bus,
  output logic             bus_conflict
);
  logic [WIDTH-1:0] r_q [8];
  logic [WIDTH-1:0] r_d [8];
  logic [WIDTH-1:0] a_q, a_d, g_q, g_d;

  // AND-OR bus: every enabled source is ORed in, no tristates
  always_comb begin
    bus = ext_data_en ? ext_data : '0;
    for (int i = 0; i < 8; i++) bus = bus | (reg_out_en[i] ? r_q[i] : '0);
    bus = bus | (alu_out_en ? g_q : '0);
  end

  // G sees the pre-edge A and the current bus (which may be the old G itself)
  always_comb begin
    for (int i = 0; i < 8; i++) r_d[i] = reg_in_en[i] ? bus : r_q[i];
    a_d = alu_reg_en ? bus : a_q;
    g_d = g_reg_en ? (alu_sel ? a_q - bus : a_q + bus) : g_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
      a_q <= '0;
      g_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) r_q[i] <= r_d[i];
      a_q <= a_d;
      g_q <= g_d;
    end
  end

`ifdef BUS_CONFLICT_CHECK_EN
  logic [9:0] src;
  assign src = {ext_data_en, reg_out_en, alu_out_en};
  // clearing the lowest set bit leaves something only if two or more were set
  assign bus_conflict = |(src & (src - 10'd1));
  always @(posedge clk) if (bus_conflict) $error("datapath: bus conflict, sources=%b", src);
`else
  assign bus_conflict = 1'b0;
`endif
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: table-driven directed checks of the datapath bus, loads and ALU
module tb_datapath;
`ifdef BUS_CONFLICT_CHECK_EN
  localparam logic CONF = 1'b1;
`else
  localparam logic CONF = 1'b0;
`endif
  logic        clk = 0, rst_n = 0;
  logic [15:0] ext_data = 0;
  logic        ext_data_en = 0, alu_reg_en = 0, alu_sel = 0, g_reg_en = 0, alu_out_en = 0;
  logic [7:0]  reg_in_en = 0, reg_out_en = 0;
  logic [15:0] bus;
  logic        bus_conflict;
  int          n_run = 0, n_fail = 0;

  datapath dut (
    .clk(clk), .rst_n(rst_n), .ext_data(ext_data), .ext_data_en(ext_data_en),
    .reg_in_en(reg_in_en), .reg_out_en(reg_out_en), .alu_reg_en(alu_reg_en),
    .alu_sel(alu_sel), .g_reg_en(g_reg_en), .alu_out_en(alu_out_en),
    .bus(bus), .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ed;
    logic        ede;
    logic [7:0]  rin;
    logic [7:0]  rout;
    logic        ar, sel, ge, ao;
    logic [15:0] exp_bus;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [15:0] ed, logic ede, logic [7:0] rin, logic [7:0] rout,
                              logic ar, logic sel, logic ge, logic ao, logic [15:0] exp_bus);
    vec_t v;
    v.ed = ed; v.ede = ede; v.rin = rin; v.rout = rout;
    v.ar = ar; v.sel = sel; v.ge = ge; v.ao = ao; v.exp_bus = exp_bus;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    ext_data = v.ed; ext_data_en = v.ede; reg_in_en = v.rin; reg_out_en = v.rout;
    alu_reg_en = v.ar; alu_sel = v.sel; g_reg_en = v.ge; alu_out_en = v.ao;
  endtask

  // drive one cycle's controls after a rising edge and check the bus before the next one
  task automatic step(string name, vec_t v);
    @(posedge clk);
    #1 drive(v);
    #1 chk(name, bus, v.exp_bus);
    chk({name, "_conf"}, {15'd0, bus_conflict}, 16'd0);
  endtask

  initial begin
    //        ed       ede rin    rout   ar sel ge ao  bus
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000));
    tv.push_back(mk(16'h0001, 1, 8'h01, 8'h00, 0, 0, 0, 0, 16'h0001)); // R0=1
    tv.push_back(mk(16'h0003, 0, 8'h00, 8'h01, 0, 0, 0, 0, 16'h0001)); // ext change ignored
    tv.push_back(mk(16'h0003, 0, 8'h01, 8'h00, 0, 0, 0, 0, 16'h0000)); // empty-bus load
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h01, 0, 0, 0, 0, 16'h0000));
    tv.push_back(mk(16'h0005, 1, 8'h02, 8'h00, 0, 0, 0, 0, 16'h0005)); // R1=5
    tv.push_back(mk(16'h0007, 1, 8'h04, 8'h00, 0, 0, 0, 0, 16'h0007)); // R2=7
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h02, 1, 0, 0, 0, 16'h0005)); // A=5
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h04, 0, 0, 1, 0, 16'h0007)); // G=12
    tv.push_back(mk(16'h0000, 0, 8'h08, 8'h00, 0, 0, 0, 1, 16'h000C)); // R3=12
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h08, 0, 0, 0, 0, 16'h000C));
    tv.push_back(mk(16'h0003, 1, 8'h00, 8'h00, 1, 0, 0, 0, 16'h0003)); // A=3
    tv.push_back(mk(16'h0005, 1, 8'h00, 8'h00, 0, 1, 1, 0, 16'h0005)); // G=3-5
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 1, 16'hFFFE));
    tv.push_back(mk(16'hFFFF, 1, 8'h00, 8'h00, 1, 0, 0, 0, 16'hFFFF)); // A=FFFF
    tv.push_back(mk(16'h0001, 1, 8'h00, 8'h00, 0, 0, 1, 0, 16'h0001)); // G=FFFF+1
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 1, 16'h0000));
    tv.push_back(mk(16'h0002, 1, 8'h00, 8'h00, 1, 0, 1, 0, 16'h0002)); // A=2, G=old A+2=1
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 1, 16'h0001));
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 1, 1, 16'h0001)); // G=A+G=3
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 1, 16'h0003));
    tv.push_back(mk(16'h0000, 0, 8'h08, 8'h08, 0, 0, 0, 0, 16'h000C)); // R3 self-reload
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h08, 0, 0, 0, 0, 16'h000C));
    tv.push_back(mk(16'hABCD, 1, 8'hF0, 8'h00, 0, 0, 0, 0, 16'hABCD)); // R4-R7 together
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h10, 0, 0, 0, 0, 16'hABCD));
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h80, 0, 0, 0, 0, 16'hABCD));
    tv.push_back(mk(16'h0000, 0, 8'h00, 8'h02, 0, 0, 0, 0, 16'h0005)); // R1 untouched

    #12 rst_n = 1;
    for (int k = 0; k < tv.size(); k++) step($sformatf("vec%0d", k), tv[k]);

    // asynchronous reset mid-cycle, with every enable held through two edges
    step("load1234", mk(16'h1234, 1, 8'h01, 8'h00, 0, 0, 0, 0, 16'h1234));
    step("rd1234", mk(16'h0000, 0, 8'h00, 8'h01, 0, 0, 0, 0, 16'h1234));
    #3 rst_n = 0;
    drive(mk(16'h5555, 1, 8'hFF, 8'h00, 1, 0, 1, 0, 16'h0000));
    repeat (2) @(posedge clk);
    #1 drive(mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000));
    #2 rst_n = 1;
    step("rst_bus", mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000));
    for (int i = 0; i < 8; i++)
      step($sformatf("rst_r%0d", i), mk(16'h0000, 0, 8'h00, 8'h01 << i, 0, 0, 0, 0, 16'h0000));
    step("rst_g", mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 1, 1, 16'h0000)); // G=A+0
    step("rst_a", mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 1, 16'h0000));

    // conflict: enabled only between edges so no edge ever sees it
    step("ldR0", mk(16'h000F, 1, 8'h01, 8'h00, 0, 0, 0, 0, 16'h000F));
    @(posedge clk);
    #1 drive(mk(16'h00F0, 1, 8'h00, 8'h01, 0, 0, 0, 0, 16'h0000));
    #1 chk("conf_bus", bus, 16'h00FF);
    chk("conf_flag", {15'd0, bus_conflict}, {15'd0, CONF});
    #1 reg_out_en = 8'h00;
    #1 chk("single_bus", bus, 16'h00F0);
    chk("single_flag", {15'd0, bus_conflict}, 16'd0);
    #1 reg_out_en = 8'h80; ext_data_en = 0; alu_out_en = 1;
    #1 chk("conf2_flag", {15'd0, bus_conflict}, {15'd0, CONF});
    #1 drive(mk(16'h0000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
